// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds fetched instruction/PC for decode, with stall hold,
// flush-to-bubble, a post-reset boot bubble window and saturating stall/flush event counters.
module if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int          BOOT_CYC = 1,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_if2ifid,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      pc4_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [31:0]      inst_ifid2idex,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc4_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int             BCW       = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYC - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BCW-1:0]   boot_cnt_q, boot_cnt_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        boot_cnt_d  = boot_cnt_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_BOOT: begin
                // Bubbles cover IROM read latency; flush is meaningless before the first fetch.
                inst_d  = NOP_INST;
                valid_d = 1'b0;
                pc_d    = '0;
                pc4_d   = '0;
                if (!stall_i) begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        boot_cnt_d = boot_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN, ST_HOLD: begin
                if (flush_i) begin
                    inst_d      = NOP_INST;
                    valid_d     = 1'b0;
                    pc_d        = pc_i;
                    pc4_d       = pc4_i;
                    flush_cnt_d = sat_inc(flush_cnt_q);
                    state_d     = ST_RUN;
                end else if (stall_i) begin
                    stall_cnt_d = sat_inc(stall_cnt_q);
                    state_d     = ST_HOLD;
                end else begin
                    inst_d  = inst_if2ifid;
                    pc_d    = pc_i;
                    pc4_d   = pc4_i;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                inst_d     = NOP_INST;
                valid_d    = 1'b0;
                pc_d       = '0;
                pc4_d      = '0;
                boot_cnt_d = '0;
                state_d    = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BOOT;
            boot_cnt_q  <= '0;
            inst_q      <= NOP_INST;
            pc_q        <= '0;
            pc4_q       <= '0;
            valid_q     <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            pc4_q       <= pc4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign inst_ifid2idex = inst_q;
    assign pc_o           = pc_q;
    assign pc4_o          = pc4_q;
    assign valid_o        = valid_q;
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Scoreboard bench for if_id_reg: instance A (BOOT_CYC=1, CNT_W=16), instance B (BOOT_CYC=3, CNT_W=4).
module tb_if_id_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, pc_i, pc4_i;
    logic        stall_i, flush_i;

    logic [31:0] inst_a, pc_a, pc4_a;
    logic        valid_a;
    logic [15:0] scnt_a, fcnt_a;
    logic [31:0] inst_b, pc_b, pc4_b;
    logic        valid_b;
    logic [3:0]  scnt_b, fcnt_b;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    if_id_reg #(.NOP_INST(NOP), .BOOT_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .inst_if2ifid(inst_i), .pc_i(pc_i), .pc4_i(pc4_i),
        .stall_i(stall_i), .flush_i(flush_i), .inst_ifid2idex(inst_a), .pc_o(pc_a),
        .pc4_o(pc4_a), .valid_o(valid_a), .stall_cnt_o(scnt_a), .flush_cnt_o(fcnt_a)
    );

    if_id_reg #(.NOP_INST(NOP), .BOOT_CYC(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .inst_if2ifid(inst_i), .pc_i(pc_i), .pc4_i(pc4_i),
        .stall_i(stall_i), .flush_i(flush_i), .inst_ifid2idex(inst_b), .pc_o(pc_b),
        .pc4_o(pc4_b), .valid_o(valid_b), .stall_cnt_o(scnt_b), .flush_cnt_o(fcnt_b)
    );

    typedef struct {
        bit          sel;
        int          id;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        bit          v;
        int          sc;
        int          fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   sel      = 1'b0;
    int   step_id  = 0;

    // Monitor: one expectation per clock edge, compared half a cycle later.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] ai, ap, ap4;
            logic        av;
            int          asc, afc;
            e = exp_q.pop_front();
            if (e.sel) begin
                ai = inst_b; ap = pc_b; ap4 = pc4_b; av = valid_b; asc = int'(scnt_b); afc = int'(fcnt_b);
            end else begin
                ai = inst_a; ap = pc_a; ap4 = pc4_a; av = valid_a; asc = int'(scnt_a); afc = int'(fcnt_a);
            end
            checks++;
            if (ai !== e.inst || ap !== e.pc || ap4 !== e.pc4 || av !== e.v || asc != e.sc || afc != e.fc) begin
                failures++;
                $display("FAIL step%0d dut%s: got inst=%h pc=%h pc4=%h v=%b sc=%0d fc=%0d want inst=%h pc=%h pc4=%h v=%b sc=%0d fc=%0d",
                         e.id, e.sel ? "B" : "A", ai, ap, ap4, av, asc, afc,
                         e.inst, e.pc, e.pc4, e.v, e.sc, e.fc);
            end
        end
    end

    task automatic step(input bit r, input bit s, input bit f,
                        input logic [31:0] ii, input logic [31:0] ip,
                        input logic [31:0] ei, input logic [31:0] ep, input bit ev,
                        input int esc, input int efc);
        exp_t e;
        rst = r; stall_i = s; flush_i = f; inst_i = ii; pc_i = ip; pc4_i = ip + 32'd4;
        @(posedge clk);
        step_id++;
        e.sel = sel; e.id = step_id; e.inst = ei; e.pc = ep;
        e.pc4 = (ep == 32'd0) ? 32'd0 : ep + 32'd4;
        e.v = ev; e.sc = esc; e.fc = efc;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; inst_i = '0; pc_i = '0; pc4_i = '0;
        @(negedge clk);

        // Reset and first capture with one boot bubble.
        sel = 1'b0;
        step(1, 0, 0, 32'h00500093, 32'h100, NOP, 0, 0, 0, 0);
        step(1, 0, 0, 32'h00500093, 32'h100, NOP, 0, 0, 0, 0);
        step(0, 0, 0, 32'h00500093, 32'h100, NOP, 0, 0, 0, 0);
        step(0, 0, 0, 32'h00500093, 32'h100, 32'h00500093, 32'h100, 1, 0, 0);
        step(0, 0, 0, 32'h00100113, 32'h104, 32'h00100113, 32'h104, 1, 0, 0);
        // Stall for three edges while inputs keep changing.
        step(0, 1, 0, 32'hAAAA0001, 32'h108, 32'h00100113, 32'h104, 1, 1, 0);
        step(0, 1, 0, 32'hAAAA0002, 32'h10C, 32'h00100113, 32'h104, 1, 2, 0);
        step(0, 1, 0, 32'hAAAA0003, 32'h110, 32'h00100113, 32'h104, 1, 3, 0);
        step(0, 0, 0, 32'h00208193, 32'h114, 32'h00208193, 32'h114, 1, 3, 0);
        // Flush beats stall in HOLD.
        step(0, 1, 0, 32'h11111111, 32'h118, 32'h00208193, 32'h114, 1, 4, 0);
        step(0, 1, 1, 32'h22222222, 32'h200, NOP, 32'h200, 0, 4, 1);
        step(0, 0, 0, 32'h00000513, 32'h204, 32'h00000513, 32'h204, 1, 4, 1);
        // Flush from RUN, then capture.
        step(0, 0, 1, 32'h33333333, 32'h300, NOP, 32'h300, 0, 4, 2);
        step(0, 0, 0, 32'h00000533, 32'h304, 32'h00000533, 32'h304, 1, 4, 2);
        // Reset in the middle of HOLD.
        step(0, 1, 0, 32'h44444444, 32'h308, 32'h00000533, 32'h304, 1, 5, 2);
        step(1, 1, 0, 32'h44444444, 32'h308, NOP, 0, 0, 0, 0);
        step(0, 0, 0, 32'h00600093, 32'h30C, NOP, 0, 0, 0, 0);
        step(0, 0, 0, 32'h00600093, 32'h30C, 32'h00600093, 32'h30C, 1, 0, 0);

        // Three-cycle boot window with stall and flush pulses on instance B.
        sel = 1'b1;
        step(1, 0, 0, 32'h0, 32'h400, NOP, 0, 0, 0, 0);
        step(1, 1, 0, 32'h0, 32'h400, NOP, 0, 0, 0, 0);
        step(0, 1, 1, 32'h0, 32'h400, NOP, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0, 32'h400, NOP, 0, 0, 0, 0);
        step(0, 0, 0, 32'h0, 32'h400, NOP, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0, 32'h400, NOP, 0, 0, 0, 0);
        step(0, 0, 0, 32'h00a00093, 32'h400, 32'h00a00093, 32'h400, 1, 0, 0);
        // Stall counter saturates at 15 in a 4-bit counter.
        for (int k = 1; k <= 20; k++) begin
            step(0, 1, 0, 32'h50000000 + 32'(k), 32'h500 + 32'(4 * k),
                 32'h00a00093, 32'h400, 1, (k > 15) ? 15 : k, 0);
        end
        step(0, 0, 0, 32'h00b00093, 32'h404, 32'h00b00093, 32'h404, 1, 15, 0);
        step(0, 0, 1, 32'h55555555, 32'h600, NOP, 32'h600, 0, 15, 1);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
